// File: rtl/bias_add_15_pkg.sv
// bias_add_15_pkg: shared sizes, state encoding and counter-width helper for the conv_15 bias stage
package bias_add_15_pkg;
  localparam int N_CH = 16;
  localparam int FRAME_PIX = 64;
  localparam int COEFF_W = 16;
  localparam int ACC_W = 32;
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bias_add_15_bias_sat_add.sv
// bias_sat_add: sign-extend a bias, add it to an accumulator one bit wider, clamp back to ACC_W
module bias_sat_add #(
  parameter int COEFF_W = bias_add_15_pkg::COEFF_W,
  parameter int ACC_W = bias_add_15_pkg::ACC_W
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [COEFF_W-1:0] bias,
  output logic [ACC_W-1:0]   sum
);
  logic [ACC_W:0] wide;
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-COEFF_W){bias[COEFF_W-1]}}, bias};
    sum = (wide[ACC_W] == wide[ACC_W-1]) ? wide[ACC_W-1:0] : {wide[ACC_W], {(ACC_W-1){!wide[ACC_W]}}};
  end
endmodule

// File: rtl/bias_add_15.sv
// bias_add_15: caches one bias per channel each frame, then adds it with saturation to the
// channel-interleaved accumulator stream through a single skid-free output register
module bias_add_15 #(
  parameter int N_CH = bias_add_15_pkg::N_CH,
  parameter int FRAME_PIX = bias_add_15_pkg::FRAME_PIX,
  parameter int COEFF_W = bias_add_15_pkg::COEFF_W,
  parameter int ACC_W = bias_add_15_pkg::ACC_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   acc_V_dout,
  input  logic               acc_V_empty_n,
  output logic               acc_V_read,
  output logic [ACC_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);
  import bias_add_15_pkg::*;
  localparam int CH_W = cnt_w(N_CH);
  localparam int PIX_W = cnt_w(FRAME_PIX);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);
  state_t state, state_nxt;
  logic [CH_W-1:0] ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [COEFF_W-1:0] cache [N_CH];
  logic out_valid;
  logic [ACC_W-1:0] out_data, sum;
  logic bias_pop, accept, ch_last, frame_last;
  bias_sat_add #(.COEFF_W(COEFF_W), .ACC_W(ACC_W)) u_add (
    .acc(acc_V_dout),
    .bias(cache[ch_cnt]),
    .sum(sum)
  );
  // reads are masked during reset so nothing is popped while the block is held
  always_comb begin
    bias_pop = (state == LOAD) && bias_V_empty_n && !ap_rst;
    accept = (state == RUN) && acc_V_empty_n && (!out_valid || output_V_full_n) && !ap_rst;
    ch_last = ch_cnt == CH_LAST;
    frame_last = ch_last && (pix_cnt == PIX_LAST);
    state_nxt = (bias_pop && ch_last) ? RUN : (accept && frame_last) ? LOAD : state;
    bias_V_read = bias_pop;
    acc_V_read = accept;
    output_V_write = out_valid;
    output_V_din = out_data;
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= LOAD;
      ch_cnt <= '0;
      pix_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (bias_pop || accept) ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
      if (accept && ch_last) pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
      out_valid <= accept || (out_valid && !output_V_full_n);
      if (accept) out_data <= sum;
    end
  end
  // bias cache survives reset; it is always fully rewritten before use
  always_ff @(posedge ap_clk) begin
    if (bias_pop) cache[ch_cnt] <= bias_V_dout;
  end
endmodule

// File: tb/tb_bias_add_15.sv
// tb_bias_add_15: directed and randomized checks of the bias stage against a frame-level reference model
module tb_bias_add_15;
  localparam int NC = 4;
  localparam int FP = 2;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int FW = NC * FP;
  logic ap_clk = 1'b0;
  logic ap_rst;
  logic [CW-1:0] bias_V_dout;
  logic bias_V_empty_n, bias_V_read;
  logic [AW-1:0] acc_V_dout;
  logic acc_V_empty_n, acc_V_read;
  logic [AW-1:0] output_V_din;
  logic output_V_full_n, output_V_write;
  logic [CW-1:0] bias_q[$];
  logic [AW-1:0] acc_q[$];
  longint exp_q[$];
  logic [AW-1:0] got_log[$];
  logic [CW-1:0] mbias [NC];
  int bias_pops, acc_pops, n_assert, n_fail, stall_cnt;
  bit bias_tog, bias_phase, acc_rand, full_rand, prev_stall, prev_acc_pop;
  logic [AW-1:0] prev_od;
  int exp_a [4] = '{101, 102, 103, 96};

  bias_add_15 #(.N_CH(NC), .FRAME_PIX(FP), .COEFF_W(CW), .ACC_W(AW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
    .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read),
    .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write)
  );

  always #5 ap_clk = !ap_clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input logic [AW-1:0] a, input logic [CW-1:0] b);
    longint hi, lo, s;
    hi = (longint'(1) <<< (AW - 1)) - 1;
    lo = -(longint'(1) <<< (AW - 1));
    s = longint'($signed(a)) + longint'($signed(b));
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    int sel = $urandom_range(0, 3);
    return sel == 0 ? 32'h7FFF_FFF0 + $urandom_range(0, 15) :
           sel == 1 ? 32'h8000_0000 + $urandom_range(0, 15) : AW'($urandom);
  endfunction

  task automatic push_frame(input bit rnd, input int b0, input int b1, input int b2, input int b3);
    if (rnd) for (int i = 0; i < NC; i++) bias_q.push_back(CW'($urandom));
    else begin
      bias_q.push_back(CW'(b0)); bias_q.push_back(CW'(b1));
      bias_q.push_back(CW'(b2)); bias_q.push_back(CW'(b3));
    end
    for (int i = 0; i < FW; i++) acc_q.push_back(rand_acc());
  endtask

  task automatic drive();
    bias_phase = !bias_phase;
    bias_V_empty_n = bias_q.size() > 0 && (!bias_tog || bias_phase);
    bias_V_dout = bias_q.size() > 0 ? bias_q[0] : '0;
    acc_V_empty_n = acc_q.size() > 0 && (!acc_rand || $urandom_range(0, 3) != 0);
    acc_V_dout = acc_q.size() > 0 ? acc_q[0] : '0;
    output_V_full_n = stall_cnt > 0 ? 1'b0 : (!full_rand || $urandom_range(0, 3) != 0);
    if (stall_cnt > 0) stall_cnt--;
  endtask

  task automatic tick();
    logic br, be, ar, ae, ow, of;
    logic [AW-1:0] od;
    @(negedge ap_clk);
    br = bias_V_read; be = bias_V_empty_n; ar = acc_V_read; ae = acc_V_empty_n;
    ow = output_V_write; of = output_V_full_n; od = output_V_din;
    if (br) chk("bias_read_while_empty", be, 1);
    if (ar) chk("acc_read_while_empty", ae, 1);
    if (br && be) chk("bias_pop_overrun", bias_pops < NC, 1);
    if (ar && ae) chk("acc_pop_before_biases", bias_pops, NC);
    if (ow && !of) chk("acc_read_in_stall", ar, 0);
    if (prev_stall) begin
      chk("stall_hold_write", ow, 1);
      chk("stall_hold_din", od, prev_od);
    end
    if (prev_acc_pop) chk("pop_to_write_latency", ow, 1);
    if (ow && of) begin
      if (exp_q.size() == 0) chk("spurious_write", exp_q.size(), 1);
      else chk("result", longint'($signed(od)), exp_q.pop_front());
      got_log.push_back(od);
    end
    prev_stall = ow && !of;
    prev_od = od;
    prev_acc_pop = ar && ae;
    @(posedge ap_clk);
    #1;
    if (br && be) begin
      if (bias_pops < NC) mbias[bias_pops] = bias_q[0];
      void'(bias_q.pop_front());
      bias_pops++;
    end
    if (ar && ae) begin
      exp_q.push_back(model(acc_q.pop_front(), mbias[acc_pops % NC]));
      acc_pops++;
      if (acc_pops == FW) begin
        acc_pops = 0;
        bias_pops = 0;
      end
    end
    drive();
  endtask

  task automatic run_drain(input string tag, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (bias_q.size() == 0 && acc_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk(tag, i < max, 1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; stall_cnt = 0;
    bias_tog = 0; bias_phase = 0; acc_rand = 0; full_rand = 0;
    prev_stall = 0; prev_acc_pop = 0; prev_od = '0;
    bias_pops = 0; acc_pops = 0;
    ap_rst = 1'b1;
    drive();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_write", output_V_write, 0);
    chk("reset_din", output_V_din, 0);
    chk("reset_acc_read", acc_V_read, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    // directed frame: biases 1,2,3,-4 on four accumulators of 100
    got_log.delete();
    bias_q.push_back(16'd1); bias_q.push_back(16'd2); bias_q.push_back(16'd3); bias_q.push_back(16'hFFFC);
    repeat (NC) acc_q.push_back(32'd100);
    repeat (FW - NC) acc_q.push_back(rand_acc());
    drive();
    run_drain("a_drain", 100);
    chk("a_count", got_log.size(), FW);
    for (int j = 0; j < 4; j++) chk("a_out", longint'($signed(got_log[j])), exp_a[j]);
    // saturation at both rails
    got_log.delete();
    bias_q.push_back(16'd1); bias_q.push_back(16'hFFFF); bias_q.push_back(16'd5); bias_q.push_back(16'd7);
    acc_q.push_back(32'h7FFF_FFFF); acc_q.push_back(32'h8000_0000);
    repeat (FW - 2) acc_q.push_back(rand_acc());
    drive();
    run_drain("b_drain", 100);
    chk("b_sat_pos", longint'(got_log[0]), 64'h7FFF_FFFF);
    chk("b_sat_neg", longint'(got_log[1]), 64'h8000_0000);
    // five-cycle downstream stall in the middle of a frame
    got_log.delete();
    push_frame(1, 0, 0, 0, 0);
    drive();
    repeat (NC + 3) tick();
    stall_cnt = 5;
    run_drain("c_drain", 100);
    chk("c_count", got_log.size(), FW);
    // bias FIFO alternating empty/non-empty
    got_log.delete();
    bias_tog = 1;
    push_frame(1, 0, 0, 0, 0);
    drive();
    run_drain("d_drain", 100);
    chk("d_count", got_log.size(), FW);
    bias_tog = 0;
    // two back-to-back frames with distinct bias sets queued at once
    got_log.delete();
    push_frame(0, 10, -20, 30, -40);
    push_frame(0, -1000, 2000, -3000, 4000);
    drive();
    run_drain("e_drain", 200);
    chk("e_count", got_log.size(), 2 * FW);
    // random throttling on every interface
    got_log.delete();
    acc_rand = 1; full_rand = 1; bias_tog = 1;
    repeat (4) push_frame(1, 0, 0, 0, 0);
    drive();
    run_drain("r_drain", 800);
    chk("r_count", got_log.size(), 4 * FW);
    acc_rand = 0; full_rand = 0; bias_tog = 0;
    // asynchronous reset after three outputs of a frame
    got_log.delete();
    push_frame(1, 0, 0, 0, 0);
    push_frame(1, 0, 0, 0, 0);
    drive();
    for (int k = 0; k < 100 && got_log.size() < 3; k++) tick();
    chk("f_progress", got_log.size() >= 3, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("f_rst_write", output_V_write, 0);
    chk("f_rst_din", output_V_din, 0);
    chk("f_rst_acc_read", acc_V_read, 0);
    chk("f_rst_bias_read", bias_V_read, 0);
    bias_q.delete(); acc_q.delete(); exp_q.delete();
    bias_pops = 0; acc_pops = 0; prev_stall = 0; prev_acc_pop = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    got_log.delete();
    push_frame(1, 0, 0, 0, 0);
    drive();
    run_drain("f_drain", 100);
    chk("f_count", got_log.size(), FW);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
